i2s_adc_capture: RTL and testbench

I2S receiver for the WM8731 ADC path. It samples i2s_adcdat on i2s_bclk rising edges and deserialises one DATA_BITS word per channel. Each completed left/right pair is written into a block-RAM ring buffer as two sign-extended 32-bit words, and every word is also presented on a one-cycle strobe output. It is the capture-side counterpart of the BRAM-to-DAC playback path. It uses the same clk (73.728 MHz) and the same fabric-generated bclk/lrclk.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_adc_capture_sync.sv | 40 ++++
 rtl/i2s_adc_capture.sv | 173 +++++++++++++++++
 tb/tb_i2s_adc_capture.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the WM8731 capture and playback paths.
// Capture FSM encoding plus clocking constants common to both directions.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } cap_state_t;

  localparam int DEFAULT_DATA_BITS = 24;
  localparam int BCLK_DIV          = 32;

endpackage

// File: rtl/i2s_adc_capture_sync.sv
// I2S input conditioning: synchronisers for bclk/lrclk/adcdat and
// detection of bclk rising edges and word-select change edges.
module i2s_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_bclk,
  input  logic i_lrclk,
  input  logic i_adcdat,
  output logic o_rise,
  output logic o_change,
  output logic o_lr_prev,
  output logic o_adcdat
);

  logic [2:0] r_bclk;
  logic [1:0] r_lrclk;
  logic [1:0] r_dat;
  logic       r_lr_prev;

  assign o_rise    = r_bclk[1] & ~r_bclk[2];
  assign o_change  = o_rise & (r_lrclk[1] != r_lr_prev);
  assign o_lr_prev = r_lr_prev;
  assign o_adcdat  = r_dat[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bclk    <= '0;
      r_lrclk   <= '0;
      r_dat     <= '0;
      r_lr_prev <= 1'b0;
    end else begin
      r_bclk  <= {r_bclk[1:0], i_bclk};
      r_lrclk <= {r_lrclk[0], i_lrclk};
      r_dat   <= {r_dat[0], i_adcdat};
      if (o_rise)
        r_lr_prev <= r_lrclk[1];
    end
  end

endmodule

// File: rtl/i2s_adc_capture.sv
// I2S ADC receiver: deserialises L/R words and writes each
// complete pair into a BRAM ring buffer as sign-extended words.
module i2s_adc_capture
  import i2s_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int DEPTH     = 12000,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_adcdat,
  output logic              sample_valid,
  output logic              sample_right,
  output logic [31:0]       sample_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  output logic [15:0]       frame_count,
  output logic [7:0]        err_count
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  logic w_rise, w_change, w_lr_prev, w_dat;

  i2s_in_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_bclk    (i2s_bclk),
    .i_lrclk   (i2s_lrclk),
    .i_adcdat  (i2s_adcdat),
    .o_rise    (w_rise),
    .o_change  (w_change),
    .o_lr_prev (w_lr_prev),
    .o_adcdat  (w_dat)
  );

  cap_state_t r_state, w_next;
  logic       w_run, w_sync_go, w_clr;

  logic [DATA_BITS-2:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_held;
  logic [31:0]          r_left, r_rword;
  logic                 r_wr1, r_wr2;
  logic [ADDR_W-1:0]    r_addr;

  logic                 r_valid, r_right;
  logic [31:0]          r_data;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr_o;
  logic [31:0]          r_din;
  logic [15:0]          r_frames;
  logic [7:0]           r_err;

  logic [DATA_BITS-1:0] w_word;
  logic [31:0]          w_sext;
  logic                 w_ok;

  assign w_word = {r_shift, w_dat};
  assign w_sext = {{(32-DATA_BITS){w_word[DATA_BITS-1]}}, w_word};
  assign w_ok   = (r_bit_cnt == CNT_W'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (enable) w_next = SYNC;
      SYNC:    if (!enable) w_next = IDLE;
               else if (w_change) w_next = RUN;
      RUN:     if (!enable) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_run     = 1'b0;
    w_sync_go = 1'b0;
    w_clr     = ~enable;
    unique case (r_state)
      SYNC:    w_sync_go = enable & w_change;
      RUN:     w_run     = enable;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_held    <= 1'b0;
      r_left    <= '0;
      r_rword   <= '0;
      r_wr1     <= 1'b0;
      r_wr2     <= 1'b0;
      r_addr    <= '0;
      r_valid   <= 1'b0;
      r_right   <= 1'b0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_addr_o  <= '0;
      r_din     <= '0;
      r_frames  <= '0;
      r_err     <= '0;
    end else begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      // Write pair runs to completion regardless of enable
      if (r_wr1) begin
        r_we     <= 1'b1;
        r_addr_o <= r_addr;
        r_din    <= r_left;
        r_wr1    <= 1'b0;
        r_wr2    <= 1'b1;
      end else if (r_wr2) begin
        r_we     <= 1'b1;
        r_addr_o <= r_addr + ADDR_W'(1);
        r_din    <= r_rword;
        r_wr2    <= 1'b0;
        r_frames <= r_frames + 16'd1;
        if (r_addr == ADDR_W'(DEPTH - 2)) r_addr <= '0;
        else r_addr <= r_addr + ADDR_W'(2);
      end
      if (w_clr) begin
        r_held    <= 1'b0;
        r_bit_cnt <= '0;
      end else if (w_sync_go) begin
        r_bit_cnt <= '0;
      end else if (w_run && w_rise) begin
        r_shift <= w_word[DATA_BITS-2:0];
        if (w_change) begin
          r_bit_cnt <= '0;
          if (w_ok) begin
            r_valid <= 1'b1;
            r_data  <= w_sext;
            r_right <= w_lr_prev;
            if (!w_lr_prev) begin
              r_left <= w_sext;
              r_held <= 1'b1;
            end else if (r_held) begin
              r_rword <= w_sext;
              r_held  <= 1'b0;
              r_wr1   <= 1'b1;
            end
          end else begin
            r_held <= 1'b0;
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          end
        end else if (r_bit_cnt != CNT_W'(DATA_BITS)) begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign sample_valid = r_valid;
  assign sample_right = r_right;
  assign sample_data  = r_data;
  assign bram_we      = r_we;
  assign bram_addr    = r_addr_o;
  assign bram_din     = r_din;
  assign frame_count  = r_frames;
  assign err_count    = r_err;

endmodule

// File: tb/tb_i2s_adc_capture.sv
// Directed bench for i2s_adc_capture with a 4-word ring buffer.
// Strobes and BRAM writes are logged on the falling clock edge.
module tb_i2s_adc_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        adcdat = 1'b0;
  logic        sample_valid, sample_right, bram_we;
  logic [31:0] sample_data, bram_addr, bram_din;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  i2s_adc_capture #(.DATA_BITS(24), .DEPTH(4), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .i2s_bclk     (bclk),
    .i2s_lrclk    (lrclk),
    .i2s_adcdat   (adcdat),
    .sample_valid (sample_valid),
    .sample_right (sample_right),
    .sample_data  (sample_data),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din),
    .frame_count  (frame_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit pend = 1'b0;
  logic [31:0] wa[$], wd[$], sd[$];
  logic        sr[$];
  int          wc[$], sc[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (sample_valid === 1'b1) begin
      sd.push_back(sample_data);
      sr.push_back(sample_right);
      sc.push_back(cyc);
    end
    if (bram_we === 1'b1) begin
      wa.push_back(bram_addr);
      wd.push_back(bram_din);
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_w(input int i, input logic [31:0] a,
                       input logic [31:0] d);
    if (i < wa.size()) begin
      chk($sformatf("waddr%0d", i), wa[i], a);
      chk($sformatf("wdata%0d", i), wd[i], d);
    end else chk($sformatf("wcount>%0d", i), wa.size(), i + 1);
  endtask

  task automatic chk_s(input int i, input logic r, input logic [31:0] d);
    if (i < sd.size()) begin
      chk($sformatf("sright%0d", i), {31'b0, sr[i]}, {31'b0, r});
      chk($sformatf("sdata%0d", i), sd[i], d);
    end else chk($sformatf("scount>%0d", i), sd.size(), i + 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {29'b0, sample_valid, sample_right, bram_we}, 0);
    chk({tag, "_sdata"}, sample_data, 0);
    chk({tag, "_addr"}, bram_addr, 0);
    chk({tag, "_din"}, bram_din, 0);
    chk({tag, "_cnt"}, {8'b0, frame_count, err_count}, 0);
  endtask

  task automatic send_bit(input logic lr, input logic d);
    bclk = 1'b0;
    lrclk = lr;
    adcdat = d;
    repeat (16) @(negedge clk);
    bclk = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // First bit of a half is the previous word's LSB (one-bit delay)
  task automatic send_half(input logic lr, input logic [23:0] w,
                           input int n);
    send_bit(lr, pend);
    for (int i = 1; i < n; i++) send_bit(lr, w[24-i]);
    pend = w[24-n];
  endtask

  task automatic clear_q();
    wa.delete(); wd.delete(); wc.delete();
    sd.delete(); sr.delete(); sc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_q();
    pend = 1'b0;
    send_half(1'b1, 24'h0, 24);
  endtask

  initial begin
    // 1: reset with toggling inputs, then idle with enable low
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check_zero("t1_rst");
    chk("t1_rst_writes", wa.size(), 0);
    rst = 1'b0;
    send_half(1'b1, 24'h5A5A5A, 24);
    send_half(1'b0, 24'hA5A5A5, 24);
    send_half(1'b1, 24'h5A5A5A, 24);
    chk("t1_en0_writes", wa.size(), 0);
    chk("t1_en0_strobes", sd.size(), 0);
    check_zero("t1_idle");

    // 2: basic pair with sign extension
    do_reset();
    enable = 1'b1;
    send_half(1'b0, 24'h123456, 24);
    send_half(1'b1, 24'hABCDEF, 24);
    send_half(1'b0, 24'h000000, 24);
    chk("t2_strobes", sd.size(), 2);
    chk_s(0, 1'b0, 32'h00123456);
    chk_s(1, 1'b1, 32'hFFABCDEF);
    chk("t2_writes", wa.size(), 2);
    chk_w(0, 32'd0, 32'h00123456);
    chk_w(1, 32'd1, 32'hFFABCDEF);
    chk("t2_gap_sw", (wc.size() > 0 && sc.size() > 1) ?
        wc[0] - sc[1] : -1, 1);
    chk("t2_gap_ww", (wc.size() > 1) ? wc[1] - wc[0] : -1, 1);
    chk("t2_frames", {16'b0, frame_count}, 1);
    chk("t2_err", {24'b0, err_count}, 0);

    // 3: enable mid left half
    do_reset();
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 14; i++) send_bit(1'b0, 1'b1);
    pend = 1'b1;
    send_half(1'b1, 24'h111111, 24);
    send_half(1'b0, 24'h222222, 24);
    send_half(1'b1, 24'h333333, 24);
    send_half(1'b0, 24'h000000, 24);
    chk("t3_strobes", sd.size(), 3);
    chk_s(0, 1'b1, 32'h00111111);
    chk("t3_writes", wa.size(), 2);
    chk_w(0, 32'd0, 32'h00222222);
    chk_w(1, 32'd1, 32'h00333333);
    chk("t3_frames", {16'b0, frame_count}, 1);

    // 4: ring wrap at DEPTH=4
    do_reset();
    enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_half(1'b0, 24'(2 * f + 1), 24);
      send_half(1'b1, 24'(2 * f + 2), 24);
    end
    send_half(1'b0, 24'h000000, 24);
    chk("t4_writes", wa.size(), 6);
    for (int i = 0; i < 6; i++) chk_w(i, i % 4, i + 1);
    chk("t4_frames", {16'b0, frame_count}, 3);

    // 5: short left half gives a framing error
    do_reset();
    enable = 1'b1;
    send_half(1'b0, 24'h800001, 24);
    send_half(1'b1, 24'h7FFFFF, 24);
    send_half(1'b0, 24'h555555, 20);
    send_half(1'b1, 24'h0F0F0F, 24);
    send_half(1'b0, 24'hFEDCBA, 24);
    send_half(1'b1, 24'h000100, 24);
    send_half(1'b0, 24'h000000, 24);
    chk("t5_err", {24'b0, err_count}, 1);
    chk("t5_strobes", sd.size(), 5);
    chk_s(2, 1'b1, 32'h000F0F0F);
    chk("t5_writes", wa.size(), 4);
    chk_w(0, 32'd0, 32'hFF800001);
    chk_w(1, 32'd1, 32'h007FFFFF);
    chk_w(2, 32'd2, 32'hFFFEDCBA);
    chk_w(3, 32'd3, 32'h00000100);
    chk("t5_frames", {16'b0, frame_count}, 2);

    // 6: reset between the two writes of a pair
    do_reset();
    enable = 1'b1;
    send_half(1'b0, 24'h765432, 24);
    send_half(1'b1, 24'h89ABCD, 24);
    fork
      send_half(1'b0, 24'h000000, 24);
      begin
        for (int k = 0; k < 2000 && bram_we !== 1'b1; k++)
          @(negedge clk);
        chk("t6_w1_seen", {31'b0, bram_we}, 1);
        chk("t6_w1_addr", bram_addr, 0);
        chk("t6_w1_din", bram_din, 32'h00765432);
        rst = 1'b1;
        @(negedge clk);
        check_zero("t6_rst");
        rst = 1'b0;
      end
    join
    chk("t6_no_w2", wa.size(), 1);
    clear_q();
    send_half(1'b1, 24'h000000, 24);
    send_half(1'b0, 24'h0000AA, 24);
    send_half(1'b1, 24'hFFFFFF, 24);
    send_half(1'b0, 24'h000000, 24);
    chk("t6_strobes", sd.size(), 3);
    chk("t6_writes", wa.size(), 2);
    chk_w(0, 32'd0, 32'h000000AA);
    chk_w(1, 32'd1, 32'hFFFFFFFF);
    chk("t6_frames", {16'b0, frame_count}, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
